// File: rtl/snake_tick_ctrl.sv
// snake_tick_ctrl: move-tick generator, direction arbiter and play-state FSM for the snake datapath.
// Build macro SNAKE_SPEEDUP_EN: each food eaten shortens the move period, floored at MIN_DIV.
module snake_tick_ctrl #(
    parameter logic [23:0] TICK_DIV = 24'd5_000_000,
    parameter logic [23:0] MIN_DIV  = 24'd1_000_000,
    parameter logic [23:0] DIV_STEP = 24'd250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic [9:0] length,
    input  logic       is_end,
    input  logic       bite_self,
    input  logic       eat,
    output logic       move_rst,
    output logic       vld,
    output logic [3:0] way,
    output logic       pixel_done,
    output logic       game_over,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_MOVE,
        S_BODY,
        S_OVER
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start_game;
    logic        w_active;
    logic        w_wrap;
    logic        w_take_tick;
    logic        w_wd_expired;
    logic        w_btn_ok;
    logic [23:0] w_period;
    logic [23:0] r_cnt;
    logic [23:0] r_cur_period;
    logic        r_tick_pend;
    logic        r_is_end;
    logic [10:0] r_wd;
    logic [3:0]  r_way;
    logic [3:0]  r_pend_dir;
    logic        r_move_rst;
    logic        r_vld;
    logic        r_pixel_done;
    logic        r_game_over;
    logic        r_overrun;

    function automatic logic f_onehot(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

    // right<->left and up<->down swap bit pairs
    function automatic logic [3:0] f_reverse(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    assign w_active     = (r_state == S_WAIT_TICK) || (r_state == S_MOVE) || (r_state == S_BODY);
    assign w_wrap       = w_active && (r_cnt == r_cur_period - 24'd1);
    assign w_take_tick  = (r_state == S_WAIT_TICK) && (w_next == S_MOVE);
    assign w_wd_expired = (r_wd == ({1'b0, length} + 11'd3));
    assign w_btn_ok     = f_onehot(btn) && (btn != f_reverse(r_way));

`ifdef SNAKE_SPEEDUP_EN
    logic [23:0] r_period;

    function automatic logic [23:0] f_sat_dec(input logic [23:0] p);
        if ({1'b0, p} >= ({1'b0, MIN_DIV} + {1'b0, DIV_STEP}))
            return p - DIV_STEP;
        else if (p > MIN_DIV)
            return MIN_DIV;
        else
            return p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_period <= TICK_DIV;
        else if (w_start_game)
            r_period <= TICK_DIV;
        else if (w_active && eat)
            r_period <= f_sat_dec(r_period);
    end

    assign w_period = r_period;
`else
    logic w_unused;
    assign w_unused = ^{eat, MIN_DIV, DIV_STEP};
    assign w_period = TICK_DIV;
`endif

    always_comb begin
        w_next       = r_state;
        w_start_game = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next       = S_WAIT_TICK;
                    w_start_game = 1'b1;
                end
            end
            S_WAIT_TICK: begin
                if (bite_self)
                    w_next = S_OVER;
                else if (r_tick_pend)
                    w_next = S_MOVE;
            end
            S_MOVE: begin
                w_next = bite_self ? S_OVER : S_BODY;
            end
            S_BODY: begin
                if (bite_self)
                    w_next = S_OVER;
                else if (r_is_end || w_wd_expired)
                    w_next = S_WAIT_TICK;
            end
            S_OVER: begin
                if (start)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_is_end <= 1'b0;
            r_wd     <= 11'd0;
        end else begin
            r_state  <= w_next;
            r_is_end <= is_end;
            r_wd     <= (r_state == S_BODY) ? r_wd + 11'd1 : 11'd0;
        end
    end

    // The active period is latched at each wrap so a speed-up never truncates a running count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 24'd0;
            r_cur_period <= TICK_DIV;
            r_tick_pend  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_start_game) begin
            r_cnt        <= 24'd0;
            r_cur_period <= TICK_DIV;
            r_tick_pend  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_wrap) begin
            r_cnt        <= 24'd0;
            r_cur_period <= w_period;
            r_tick_pend  <= 1'b1;
            if (r_tick_pend && !w_take_tick)
                r_overrun <= 1'b1;
        end else if (w_active) begin
            r_cnt <= r_cnt + 24'd1;
            if (w_take_tick)
                r_tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_way      <= 4'b1000;
            r_pend_dir <= 4'b1000;
        end else if (w_start_game) begin
            r_way      <= 4'b1000;
            r_pend_dir <= 4'b1000;
        end else begin
            if (w_btn_ok)
                r_pend_dir <= btn;
            if (w_take_tick && (r_pend_dir != f_reverse(r_way)))
                r_way <= r_pend_dir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move_rst   <= 1'b1;
            r_vld        <= 1'b0;
            r_pixel_done <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_move_rst   <= (w_next == S_IDLE);
            r_vld        <= (w_next == S_MOVE);
            r_pixel_done <= (w_next == S_BODY);
            if (w_start_game)
                r_game_over <= 1'b0;
            else if (w_next == S_OVER)
                r_game_over <= 1'b1;
        end
    end

    assign move_rst   = r_move_rst;
    assign vld        = r_vld;
    assign way        = r_way;
    assign pixel_done = r_pixel_done;
    assign game_over  = r_game_over;
    assign overrun    = r_overrun;

endmodule
